// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and lane count for the byte-serial memory controller.
package mem_ctrl_pkg;
   typedef enum logic [2:0] {MemIdle, MemRd, MemRdLast, MemWr, MemDone} mem_state_t;
   localparam int MemLanes = 4;
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences 32-bit data/fetch requests as four byte accesses on a shared byte-wide synchronous RAM.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_r_enable_i,
   input  logic              ram_w_enable_i,
   input  logic [3:0]        ram_w_mask_i,
   input  logic [31:0]       ram_w_data_i,
   input  logic [31:0]       ram_addr_i,
   output logic [31:0]       ram_r_data_o,
   output logic              ram_busy_o,
   output logic              ram_done_o,
   input  logic              if_r_enable_i,
   input  logic [31:0]       if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wr_o,
   output logic [7:0]        mem_dout_o,
   input  logic [7:0]        mem_din_i
);
   mem_state_t        r_state;
   logic [ADDR_W-1:0] r_base;
   logic [1:0]        r_lane;
   logic [3:0]        r_mask;
   logic [31:0]       r_data;
   logic              r_own_if;
   logic [23:0]       r_buf;
   logic [31:0]       r_ram_rdata;
   logic [31:0]       r_if_rdata;
   logic              w_data_req;
   logic [31:0]       w_addr;
   logic              w_drive;
   logic              w_last_lane;
   logic              w_unused;

   assign w_data_req  = ram_w_enable_i | ram_r_enable_i;
   assign w_addr      = w_data_req ? ram_addr_i : if_addr_i;
   assign w_drive     = (r_state == MemRd) | (r_state == MemWr);
   assign w_last_lane = r_lane == 2'(MemLanes - 1);
   assign w_unused    = ^{ram_addr_i[31:ADDR_W], ram_addr_i[1:0], if_addr_i[31:ADDR_W], if_addr_i[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= MemIdle;
         r_base      <= '0;
         r_lane      <= '0;
         r_mask      <= '0;
         r_data      <= '0;
         r_own_if    <= 1'b0;
         r_buf       <= '0;
         r_ram_rdata <= '0;
         r_if_rdata  <= '0;
      end else begin
         case (r_state)
            MemIdle: if (w_data_req | if_r_enable_i) begin
               r_base   <= {w_addr[ADDR_W-1:2], 2'b00};
               r_mask   <= ram_w_mask_i;
               r_data   <= ram_w_data_i;
               r_own_if <= ~w_data_req;
               r_lane   <= '0;
               r_state  <= ram_w_enable_i ? MemWr : MemRd;
            end
            // mem_din_i lags the address by a cycle; after four shifts r_buf holds bytes 2..0
            MemRd: begin
               r_buf   <= {mem_din_i, r_buf[23:8]};
               r_lane  <= r_lane + 2'd1;
               r_state <= w_last_lane ? MemRdLast : MemRd;
            end
            MemRdLast: begin
               if (r_own_if) r_if_rdata <= {mem_din_i, r_buf};
               else r_ram_rdata <= {mem_din_i, r_buf};
               r_state <= MemDone;
            end
            MemWr: begin
               r_lane  <= r_lane + 2'd1;
               r_state <= w_last_lane ? MemDone : MemWr;
            end
            MemDone: begin
               r_lane  <= '0;
               r_state <= MemIdle;
            end
            default: r_state <= MemIdle;
         endcase
      end
   end

   assign ram_busy_o   = (r_state != MemIdle) & (r_state != MemDone);
   assign ram_done_o   = (r_state == MemDone) & ~r_own_if;
   assign if_done_o    = (r_state == MemDone) & r_own_if;
   assign ram_r_data_o = r_ram_rdata;
   assign if_data_o    = r_if_rdata;
   assign mem_addr_o   = w_drive ? r_base + ADDR_W'(r_lane) : '0;
   assign mem_wr_o     = (r_state == MemWr) & r_mask[r_lane];
   assign mem_dout_o   = (r_state == MemWr) ? r_data[{r_lane, 3'b000} +: 8] : '0;
endmodule
